// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank.
//   state_e          : access FSM states (IDLE, RESP)
//   CTRL_IDX         : word index of the control register in the window
//   CTRL_*_BIT       : bit positions inside the control register
//   WINDOW_MSB/LSB   : address bits compared against the window base
package perf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [5:0] CTRL_IDX        = 6'd63;
  localparam int unsigned CTRL_FREEZE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;
  localparam int unsigned WINDOW_MSB      = 31;
  localparam int unsigned WINDOW_LSB      = 8;

endpackage

// File: rtl/perf_counter_cell.sv
// One 32-bit event counter.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (count -> 0)
//   clr_i   : synchronous clear, highest priority
//   load_i  : CPU write strobe, byte lanes selected by be_i
//   be_i    : byte lane enables for load_i
//   data_i  : CPU write data
//   inc_i   : increment enable (already gated by freeze)
//   count_o : current counter value
// Priority per edge: clear > load > increment > hold. Wraps at 2^32.
module perf_counter_cell (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] data_i,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      // A write owns the edge even when no lane is enabled, so the
      // increment is dropped rather than merged.
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) cnt_d[8*b +: 8] = data_i[8*b +: 8];
      end
    end else if (inc_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of N_CTRS 32-bit event counters plus a CTRL word.
//   clk, reset          : clock, asynchronous active-high reset
//   event_inc           : per-counter increment strobes
//   mem_address         : byte address; window selected by bits [31:8]
//   mem_read/mem_write  : held requests; both high acts as a write
//   mem_wdata           : write data
//   mem_byte_enable     : byte lane enables for writes
//   mem_rdata           : captured read data, held until the next read
//   mem_resp            : one-cycle completion pulse, cycle after acceptance
// Word i (offset 4*i) is counter i; offset 0xFC is CTRL
// (bit0 freeze R/W, bit1 clear_all write-1 pulse).
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned N_CTRS    = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CTRS-1:0] event_inc,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_byte_enable,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp
);

  state_e      state_q, state_d;
  logic        freeze_q, freeze_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_val;
  logic [31:0] ctr_val [N_CTRS];

  logic [5:0]  idx;
  logic        hit, accept, wr_acc, rd_acc, ctrl_wr, clear_all;

  assign idx    = mem_address[7:2];
  assign hit    = (mem_read | mem_write) &&
                  (mem_address[WINDOW_MSB:WINDOW_LSB] == BASE_ADDR[WINDOW_MSB:WINDOW_LSB]);
  assign accept = (state_q == IDLE) && hit;
  assign wr_acc = accept && mem_write;
  assign rd_acc = accept && !mem_write;

  assign ctrl_wr   = wr_acc && (idx == CTRL_IDX) && mem_byte_enable[0];
  assign clear_all = ctrl_wr && mem_wdata[CTRL_CLEAR_BIT];

  for (genvar g = 0; g < N_CTRS; g++) begin : g_ctr
    perf_counter_cell u_cell (
      .clk_i   (clk),
      .rst_i   (reset),
      .clr_i   (clear_all),
      .load_i  (wr_acc && (idx == 6'(g))),
      .be_i    (mem_byte_enable),
      .data_i  (mem_wdata),
      .inc_i   (event_inc[g] && !freeze_q),
      .count_o (ctr_val[g])
    );
  end

  // Read mux sees register outputs, i.e. pre-update values for this edge.
  always_comb begin
    rd_val = '0;
    if (idx == CTRL_IDX) rd_val[CTRL_FREEZE_BIT] = freeze_q;
    for (int unsigned i = 0; i < N_CTRS; i++) begin
      if (idx == 6'(i)) rd_val = ctr_val[i];
    end
  end

  always_comb begin
    freeze_d = ctrl_wr ? mem_wdata[CTRL_FREEZE_BIT] : freeze_q;
    rdata_d  = rd_acc ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      freeze_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      freeze_q <= freeze_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_resp  = (state_q == RESP);
    mem_rdata = rdata_q;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  event_inc;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int errors = 0;

  perf_counter_bank #(.N_CTRS(8), .BASE_ADDR(32'hFFFF_FF00)) dut (
    .clk             (clk),
    .reset           (reset),
    .event_inc       (event_inc),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_EV, OP_RD, OP_WR, OP_RW, OP_MISSR, OP_MISSW} op_e;

  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  ev;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(op_e op, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, logic [7:0] ev, int n, logic [31:0] exp);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.be = be;
    v.ev = ev; v.n = n; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_drive();
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_wdata = '0; mem_byte_enable = '0; event_inc = '0;
  endtask

  task automatic ev_cycles(input logic [7:0] ev, input int n);
    @(negedge clk);
    event_inc = ev;
    repeat (n) @(posedge clk);
    @(negedge clk);
    event_inc = '0;
  endtask

  // exp is the mem_rdata value required during the response cycle
  // (for writes: the previous read value, which must be held).
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic [7:0] ev, input bit hit,
                           input logic [31:0] exp, input string nm);
    @(negedge clk);
    mem_address = a; mem_wdata = wd; mem_byte_enable = be;
    mem_read = rd; mem_write = wr; event_inc = ev;
    if (hit) begin
      @(posedge clk); #1;
      check({nm, "_resp"}, {31'b0, mem_resp}, 32'd1);
      @(negedge clk);
      idle_drive();
      check({nm, "_rdata"}, mem_rdata, exp);
      @(posedge clk); #1;
      check({nm, "_resp_1cyc"}, {31'b0, mem_resp}, 32'd0);
    end else begin
      repeat (3) begin
        @(posedge clk); #1;
        check({nm, "_noresp"}, {31'b0, mem_resp}, 32'd0);
      end
      @(negedge clk);
      idle_drive();
    end
  endtask

  localparam logic [31:0] A0   = 32'hFFFF_FF00;
  localparam logic [31:0] A1   = 32'hFFFF_FF04;
  localparam logic [31:0] A2   = 32'hFFFF_FF08;
  localparam logic [31:0] A4   = 32'hFFFF_FF10;
  localparam logic [31:0] A5   = 32'hFFFF_FF14;
  localparam logic [31:0] A7   = 32'hFFFF_FF1C;
  localparam logic [31:0] AUNM = 32'hFFFF_FF50;
  localparam logic [31:0] ACTL = 32'hFFFF_FFFC;

  initial begin
    idle_drive();
    reset = 1'b1;
    #1;
    check("reset_resp", {31'b0, mem_resp}, 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    vq.push_back(mk(OP_EV, 0, 0, 0, 8'h04, 5, 0));
    vq.push_back(mk(OP_RD, A2, 0, 0, 0, 0, 32'd5));
    vq.push_back(mk(OP_RD, A0, 0, 0, 0, 0, 32'd0));
    vq.push_back(mk(OP_RD, A7, 0, 0, 0, 0, 32'd0));
    vq.push_back(mk(OP_WR, A0, 32'hFFFF_FFFE, 4'hF, 0, 0, 32'd0));
    vq.push_back(mk(OP_EV, 0, 0, 0, 8'h01, 2, 0));
    vq.push_back(mk(OP_RD, A0, 0, 0, 0, 0, 32'd0));
    vq.push_back(mk(OP_WR, A0, 32'h0000_AB00, 4'b0010, 0, 0, 32'd0));
    vq.push_back(mk(OP_RD, A0, 0, 0, 0, 0, 32'h0000_AB00));
    vq.push_back(mk(OP_WR, A0, 32'h1234_5678, 4'b1000, 0, 0, 32'h0000_AB00));
    vq.push_back(mk(OP_RD, A0, 0, 0, 0, 0, 32'h1200_AB00));
    vq.push_back(mk(OP_WR, ACTL, 32'd1, 4'hF, 0, 0, 32'h1200_AB00));
    vq.push_back(mk(OP_EV, 0, 0, 0, 8'hFF, 10, 0));
    vq.push_back(mk(OP_RD, A2, 0, 0, 0, 0, 32'd5));
    vq.push_back(mk(OP_RD, A0, 0, 0, 0, 0, 32'h1200_AB00));
    vq.push_back(mk(OP_RD, ACTL, 0, 0, 0, 0, 32'd1));
    vq.push_back(mk(OP_WR, ACTL, 32'd0, 4'hF, 0, 0, 32'd1));
    vq.push_back(mk(OP_EV, 0, 0, 0, 8'hFF, 3, 0));
    vq.push_back(mk(OP_RD, A2, 0, 0, 0, 0, 32'd8));
    vq.push_back(mk(OP_RD, A7, 0, 0, 0, 0, 32'd3));
    vq.push_back(mk(OP_RD, ACTL, 0, 0, 0, 0, 32'd0));
    // freeze changes take effect one edge after the CTRL write
    vq.push_back(mk(OP_WR, ACTL, 32'd1, 4'hF, 8'hFF, 0, 32'd0));
    vq.push_back(mk(OP_WR, ACTL, 32'd0, 4'hF, 8'hFF, 0, 32'd0));
    vq.push_back(mk(OP_RD, A1, 0, 0, 0, 0, 32'd4));
    vq.push_back(mk(OP_EV, 0, 0, 0, 8'h02, 3, 0));
    vq.push_back(mk(OP_RD, A1, 0, 0, 8'h02, 0, 32'd7));
    vq.push_back(mk(OP_RD, A1, 0, 0, 0, 0, 32'd8));
    vq.push_back(mk(OP_WR, A1, 32'h10, 4'hF, 8'h02, 0, 32'd8));
    vq.push_back(mk(OP_RD, A1, 0, 0, 0, 0, 32'h10));
    vq.push_back(mk(OP_WR, ACTL, 32'd2, 4'hF, 8'hFF, 0, 32'h10));
    vq.push_back(mk(OP_RD, A0, 0, 0, 0, 0, 32'd0));
    vq.push_back(mk(OP_RD, A7, 0, 0, 0, 0, 32'd0));
    vq.push_back(mk(OP_RD, ACTL, 0, 0, 0, 0, 32'd0));
    vq.push_back(mk(OP_EV, 0, 0, 0, 8'hFF, 1, 0));
    vq.push_back(mk(OP_RD, A5, 0, 0, 0, 0, 32'd1));
    vq.push_back(mk(OP_RD, AUNM, 0, 0, 0, 0, 32'd0));
    vq.push_back(mk(OP_WR, AUNM, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'd0));
    vq.push_back(mk(OP_RW, A4, 32'hCAFE_0000, 4'hF, 0, 0, 32'd0));
    vq.push_back(mk(OP_RD, A4, 0, 0, 0, 0, 32'hCAFE_0000));
    vq.push_back(mk(OP_MISSR, 32'h1000_0000, 0, 0, 0, 0, 0));
    vq.push_back(mk(OP_MISSW, 32'hFFFE_FF08, 32'h55, 4'hF, 0, 0, 0));
    vq.push_back(mk(OP_RD, A2, 0, 0, 0, 0, 32'd1));

    foreach (vq[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      case (vq[i].op)
        OP_EV:    ev_cycles(vq[i].ev, vq[i].n);
        OP_RD:    do_access(1'b1, 1'b0, vq[i].addr, '0, '0, vq[i].ev, 1'b1, vq[i].exp, nm);
        OP_WR:    do_access(1'b0, 1'b1, vq[i].addr, vq[i].wdata, vq[i].be, vq[i].ev, 1'b1, vq[i].exp, nm);
        OP_RW:    do_access(1'b1, 1'b1, vq[i].addr, vq[i].wdata, vq[i].be, vq[i].ev, 1'b1, vq[i].exp, nm);
        OP_MISSR: do_access(1'b1, 1'b0, vq[i].addr, '0, '0, vq[i].ev, 1'b0, '0, nm);
        OP_MISSW: do_access(1'b0, 1'b1, vq[i].addr, vq[i].wdata, vq[i].be, vq[i].ev, 1'b0, '0, nm);
        default:  ;
      endcase
    end

    // Reset asserted during the response cycle.
    ev_cycles(8'hFF, 2);
    @(negedge clk);
    mem_read = 1'b1; mem_address = A2;
    @(posedge clk); #1;
    check("rstresp_resp", {31'b0, mem_resp}, 32'd1);
    check("rstresp_rdata", mem_rdata, 32'd3);
    #2 reset = 1'b1;
    #1;
    check("rstresp_resp_drop", {31'b0, mem_resp}, 32'd0);
    check("rstresp_rdata_clr", mem_rdata, 32'd0);
    @(negedge clk);
    idle_drive();
    reset = 1'b0;
    do_access(1'b1, 1'b0, A2, '0, '0, '0, 1'b1, 32'd0, "post_rst_ctr2");
    do_access(1'b1, 1'b0, A7, '0, '0, '0, 1'b1, 32'd0, "post_rst_ctr7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Memory-mapped bank of 32-bit event counters.
- Datapath stages pulse per-event increment strobes into the bank. The CPU reads, preloads and clears the counters through a load/store port with a mem_resp handshake.
- The bank sits on the MMIO side of the memory arbiter. It answers only addresses inside its 256-byte window.

Parameters:
- N_CTRS, 8, number of counters (1..63). Counter i is at byte offset 4*i.
- BASE_ADDR, 32'hFFFF_FF00, window base. Only bits [31:8] are compared.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- event_inc  in  N_CTRS  per-counter increment strobe; each high bit adds 1 to its counter that cycle.
- mem_address  in  32  byte address of the access.
- mem_read  in  1  read request; held by the requestor until mem_resp.
- mem_write  in  1  write request; held by the requestor until mem_resp.
- mem_wdata  in  32  write data.
- mem_byte_enable  in  4  byte lane enables for writes.
- mem_rdata  out  32  read data; valid while mem_resp=1.
- mem_resp  out  1  one-cycle access-complete pulse.

Behaviour:
- Reset (asynchronous): all counters=0, freeze=0, state=IDLE, mem_resp=0, mem_rdata=0. Reset mid-access drops the access with no mem_resp; the requestor must reissue.
- Hit: (mem_read|mem_write) && mem_address[31:8]==BASE_ADDR[31:8]. Non-hits are ignored entirely.
- Index: idx = mem_address[7:2]. Offset 0xFC (idx 63) is CTRL.
  - CTRL bit0 = freeze (read/write).
  - CTRL bit1 = clear_all (write-1 pulse; reads as 0).
  - All other CTRL bits read as 0.
- FSM states: IDLE, RESP.
  - IDLE + hit: the access is performed at that clock edge and mem_rdata is captured. Next state is RESP.
  - RESP: mem_resp=1 for exactly one cycle, then IDLE unconditionally. Request inputs are ignored during RESP.
  - Latency: mem_resp is high in the cycle after the request is first sampled. Back-to-back accesses take 2 cycles each.
- Read data:
  - idx<N_CTRS returns the counter value before any same-edge update (pre-increment).
  - CTRL returns {30'b0, 1'b0, freeze}.
  - Any other idx returns 0.
  - mem_rdata holds its value until the next accepted read. Writes do not change mem_rdata.
- Writes:
  - idx<N_CTRS loads the enabled byte lanes from mem_wdata. Disabled lanes keep their current value.
  - CTRL write with byte_enable[0]=1 updates freeze from wdata[0]. If wdata[1]=1, every counter becomes 0 at that edge.
  - Other idx: write is discarded but still acknowledged.
  - mem_read and mem_write both high is treated as a write.
- Counter update priority, per counter, per edge: clear_all > CPU write > (event_inc[i] && !freeze) increment > hold.
- Arithmetic: unsigned 32-bit. 0xFFFF_FFFF+1 wraps to 0 with no sticky overflow flag.
- Increments while frozen are dropped, not queued. Freeze takes effect on the edge after the CTRL write, so the write edge itself still uses the old freeze value.

Decomposition:
- Package perf_pkg holds:
  - state enum (IDLE, RESP)
  - CTRL_IDX=6'd63
  - CTRL_FREEZE_BIT=0, CTRL_CLEAR_BIT=1
  - WINDOW_MSB=31, WINDOW_LSB=8
- Sub-module perf_counter_cell: one 32-bit counter with async reset, clear, byte-masked load and increment-enable inputs, applying the priority above. perf_counter_bank instantiates N_CTRS cells in a generate loop and owns decode, FSM, freeze and the read mux.

Test Plan:
- Reset, then 5 cycles with event_inc[2]=1, then read 0xFFFFFF08 -> mem_resp exactly 1 cycle after the request; mem_rdata=5; other counters read 0.
- Write 0xFFFF_FFFE to ctr0 (be=4'hF), then 2 event pulses, then read -> 0x0000_0000 (wrap); then a write with be=4'b0010, wdata=0x0000_AB00 -> read returns 0x0000_AB00.
- Write CTRL=1 (freeze), hold event_inc=all-ones for 10 cycles -> counters unchanged and CTRL reads 1; write CTRL=0, then 3 events -> counters advance by exactly 3.
- Event on ctr1 in the same edge as the accepted read of ctr1 (value 7) -> mem_rdata=7; a subsequent read returns 8. Event in the same edge as a write of 0x10 -> 0x10.
- Write CTRL=2 while all counters are nonzero and events are active -> all counters read 0; freeze stays 0; CTRL reads 0.
- Read idx 20 (unmapped) -> rdata=0 with resp. Access to 0x1000_0000 -> no resp. Assert reset in the RESP cycle -> mem_resp drops immediately and all counters=0.
